// File: rtl/arm_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller.
// Opcode patterns here are the single source for the decoder and the sign-extend unit.
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_LDUR = 3'd0,
    C_STUR = 3'd1,
    C_CBZ  = 3'd2,
    C_ADD  = 3'd3,
    C_SUB  = 3'd4,
    C_AND  = 3'd5,
    C_ORR  = 3'd6,
    C_ILL  = 3'd7
  } iclass_t;

  // instr[31:21] patterns; CBZ ignores its low three bits.
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_CBZ  = 11'b1011010_0???;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;

  localparam logic [3:0] ALUCTL_AND   = 4'b0000;
  localparam logic [3:0] ALUCTL_ORR   = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD   = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB   = 4'b0110;
  localparam logic [3:0] ALUCTL_PASSB = 4'b0111;

  function automatic logic [3:0] alu_ctl(input iclass_t c);
    case (c)
      C_LDUR, C_STUR, C_ADD: alu_ctl = ALUCTL_ADD;
      C_SUB:                 alu_ctl = ALUCTL_SUB;
      C_AND:                 alu_ctl = ALUCTL_AND;
      C_ORR:                 alu_ctl = ALUCTL_ORR;
      C_CBZ:                 alu_ctl = ALUCTL_PASSB;
      default:               alu_ctl = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode classifier: instr[31:21] to instruction class.
module ctrl_decoder
  import arm_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output iclass_t     iclass
);

  // Match opcode against the shared patterns; anything else is illegal.
  always_comb begin
    iclass = C_ILL;
    casez (opcode)
      OP_LDUR: iclass = C_LDUR;
      OP_STUR: iclass = C_STUR;
      OP_CBZ:  iclass = C_CBZ;
      OP_ADD:  iclass = C_ADD;
      OP_SUB:  iclass = C_SUB;
      OP_AND:  iclass = C_AND;
      OP_ORR:  iclass = C_ORR;
      default: iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the LEGv8 subset: sequences fetch through writeback,
// waits on memory handshakes with a timeout, traps illegal opcodes, counts retirements.
module multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             zero,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [3:0]       alucontrol,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  iclass_t          class_q, class_d;
  iclass_t          dec_class_s, cls_s;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire_s, timed_out_s, instr_unused_s;

  assign instr_unused_s = ^instr[20:0];
  assign instret        = instret_q;

  ctrl_decoder u_dec (
    .opcode (instr[31:21]),
    .iclass (dec_class_s)
  );

  // Next-state, timer, retirement and all control outputs.
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    timer_d    = timer_q;
    retire_s   = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    // The class register is loaded at the end of DECODE, so DECODE uses the live decode.
    cls_s       = (state_q == DECODE) ? dec_class_s : class_q;
    timed_out_s = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        timer_d = '0;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (timed_out_s) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DECODE: begin
        class_d = dec_class_s;
        state_d = (dec_class_s == C_ILL) ? ERROR : EXEC;
      end
      EXEC: begin
        case (class_q)
          C_CBZ: begin
            pc_we    = 1'b1;
            pc_src   = zero;
            retire_s = 1'b1;
            state_d  = FETCH;
            timer_d  = '0;
          end
          C_LDUR, C_STUR: begin
            state_d = MEM;
            timer_d = '0;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        mem_read  = (class_q == C_LDUR);
        mem_write = (class_q == C_STUR);
        if (dmem_ready) begin
          if (class_q == C_LDUR) begin
            state_d = WB;
          end else begin
            pc_we    = 1'b1;
            retire_s = 1'b1;
            state_d  = FETCH;
            timer_d  = '0;
          end
        end else if (timed_out_s) begin
          state_d = ERROR;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (class_q == C_LDUR);
        pc_we      = 1'b1;
        retire_s   = 1'b1;
        state_d    = FETCH;
        timer_d    = '0;
      end
      ERROR: illegal = 1'b1;
      default: state_d = ERROR;
    endcase

    if (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB) begin
      reg2loc    = (cls_s == C_STUR) || (cls_s == C_CBZ);
      alu_src    = (cls_s == C_LDUR) || (cls_s == C_STUR);
      alucontrol = alu_ctl(cls_s);
    end else begin
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      alucontrol = 4'b0000;
    end

    instret_d = retire_s ? (instret_q + CNT_W'(1)) : instret_q;
  end

  // State, class, wait timer and retirement counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      class_q   <= C_ILL;
      timer_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      timer_q   <= timer_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: each issued instruction queues its expected output events,
// a monitor pops and compares whenever the controller shows a strobe.
module tb_multicycle_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, zero;
  logic        imem_req, ir_we, pc_we, pc_src, reg2loc, alu_src;
  logic [3:0]  alucontrol;
  logic        mem_read, mem_write, mem_to_reg, reg_write, illegal;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .imem_req(imem_req), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
    .alucontrol(alucontrol), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .instret(instret)
  );

  typedef struct {
    logic [14:0] outs;
    int          ret;
    int          since;
    int          req_lo;
    int          hold;
  } ev_t;

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  retired = 0;

  wire [14:0] act_outs = {imem_req, ir_we, pc_we, pc_src, reg2loc, alu_src, alucontrol,
                          mem_read, mem_write, mem_to_reg, reg_write, illegal};

  function automatic logic [14:0] pk(bit req, bit irwe, bit pcwe, bit pcsrc, bit r2l, bit asrc,
                                     logic [3:0] alu, bit mr, bit mw, bit m2r, bit rw, bit ill);
    return {req, irwe, pcwe, pcsrc, r2l, asrc, alu, mr, mw, m2r, rw, ill};
  endfunction

  // 0 LDUR, 1 STUR, 2 CBZ, 3 ADD, 4 SUB, 5 AND, 6 ORR, 7 illegal
  function automatic int kind_of(logic [31:0] ins);
    logic [10:0] op = ins[31:21];
    if (op == 11'h7C2) return 0;
    if (op == 11'h7C0) return 1;
    if (op >= 11'h5A0 && op <= 11'h5A7) return 2;
    if (op == 11'h458) return 3;
    if (op == 11'h658) return 4;
    if (op == 11'h450) return 5;
    if (op == 11'h550) return 6;
    return 7;
  endfunction

  function automatic logic [3:0] alu_of(int k);
    case (k)
      0, 1, 3: return 4'b0010;
      4:       return 4'b0110;
      5:       return 4'b0000;
      6:       return 4'b0001;
      2:       return 4'b0111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic ev_t mk(logic [14:0] o, int r, int s, int q, int h);
    ev_t e;
    e.outs = o; e.ret = r; e.since = s; e.req_lo = q; e.hold = h;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_instr(logic [31:0] ins, int df, int dm, bit z);
    int k = kind_of(ins);
    bit r2l = (k == 1 || k == 2);
    bit asrc = (k == 0 || k == 1);
    logic [3:0] alu = alu_of(k);
    sb.push_back(mk(pk(1, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0), retired, -1, df, 0));
    case (k)
      7: sb.push_back(mk(pk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1), retired, 2, 0, 0));
      2: begin
        sb.push_back(mk(pk(0, 0, 1, z, r2l, asrc, alu, 0, 0, 0, 0, 0), retired, 2, 0, 0));
        retired++;
      end
      0: begin
        sb.push_back(mk(pk(0, 0, 0, 0, r2l, asrc, alu, 1, 0, 0, 0, 0), retired, 3 + dm, 0, dm + 1));
        sb.push_back(mk(pk(0, 0, 1, 0, r2l, asrc, alu, 0, 0, 1, 1, 0), retired, 4 + dm, 0, 0));
        retired++;
      end
      1: begin
        sb.push_back(mk(pk(0, 0, 1, 0, r2l, asrc, alu, 0, 1, 0, 0, 0), retired, 3 + dm, 0, dm + 1));
        retired++;
      end
      default: begin
        sb.push_back(mk(pk(0, 0, 1, 0, r2l, asrc, alu, 0, 0, 0, 1, 0), retired, 3, 0, 0));
        retired++;
      end
    endcase
  endtask

  task automatic wait_sel(int which);
    int n = 0;
    while ((((which == 0) ? imem_req : (mem_read | mem_write)) !== 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL wait%0d: request never seen within %0d cycles", which, n);
    end
  endtask

  task automatic fetch_phase(logic [31:0] ins, int df, bit z);
    wait_sel(0);
    instr = ins;
    zero  = z;
    repeat (df) begin
      dmem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
  endtask

  task automatic run_instr(logic [31:0] ins, int df, int dm, bit z);
    int k = kind_of(ins);
    push_instr(ins, df, dm, z);
    fetch_phase(ins, df, z);
    if (k == 0 || k == 1) begin
      wait_sel(1);
      repeat (dm) begin @(posedge clk); #1; end
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
  endtask

  // Monitor: negedge sampling, event detection and scoreboard comparison.
  initial begin
    int since_c = 1000;
    int req_lo = 0;
    int hold = 0;
    bit ill_prev = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        since_c = 1000; req_lo = 0; hold = 0; ill_prev = 1'b0;
      end else begin
        since_c++;
        if (imem_req && !imem_ready) req_lo++;
        if (mem_read || mem_write) hold++;
        if (ir_we || pc_we || reg_write || ((mem_read || mem_write) && dmem_ready) ||
            (illegal && !ill_prev)) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL event: unexpected outs=%h at %0t", act_outs, $time);
          end else begin
            e = sb.pop_front();
            if (act_outs !== e.outs || instret !== e.ret || req_lo != e.req_lo ||
                hold != e.hold || (e.since >= 0 && since_c != e.since)) begin
              miscompares++;
              $display("FAIL event@%0t: got outs=%h instret=%0d lat=%0d reqwait=%0d hold=%0d expected outs=%h instret=%0d lat=%0d reqwait=%0d hold=%0d",
                       $time, act_outs, instret, since_c, req_lo, hold,
                       e.outs, e.ret, e.since, e.req_lo, e.hold);
            end
          end
          if (ir_we) since_c = 0;
          req_lo = 0;
          hold = 0;
        end
        ill_prev = illegal;
      end
    end
  end

  initial begin
    logic [10:0] op;
    int k;
    reset = 1'b0; instr = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {17'h0, act_outs}, 32'h0);
    chk("reset_instret", instret, 32'h0);
    reset = 1'b1;

    run_instr(32'h8B020020, 0, 0, 1'b0);   // ADD
    run_instr(32'hF8400020, 0, 3, 1'b0);   // LDUR, dmem 3 late
    run_instr(32'hB4000040, 1, 0, 1'b1);   // CBZ taken
    run_instr(32'hB4000040, 0, 0, 1'b0);   // CBZ not taken
    run_instr(32'hF8000020, 2, 2, 1'b0);   // STUR

    // Reset in the middle of a data-memory wait.
    push_instr(32'hF8400020, 0, 5, 1'b0);
    fetch_phase(32'hF8400020, 0, 1'b0);
    wait_sel(1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midmem_outs", {17'h0, act_outs}, 32'h0);
    chk("midmem_instret", instret, 32'h0);
    sb.delete();
    retired = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post_reset_idle", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    chk("post_reset_fetch", {31'h0, imem_req}, 32'h1);
    run_instr(32'h8B020020, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: op = 11'h7C2;
        1: op = 11'h7C0;
        2: op = 11'h5A0 | 11'($urandom_range(0, 7));
        3: op = 11'h458;
        4: op = 11'h658;
        5: op = 11'h450;
        default: op = 11'h550;
      endcase
      run_instr({op, 21'($urandom)}, $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom_range(0, 1)));
    end

    // Illegal opcode, then the trap must hold.
    run_instr(32'h00000000, 1, 0, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      chk("illegal_sticky", {31'h0, illegal}, 32'h1);
      @(posedge clk); #1;
    end
    chk("sb_empty_after_illegal", sb.size(), 32'h0);

    // Fetch timeout: imem_ready never arrives.
    reset = 1'b0;
    retired = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.push_back(mk(pk(0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1), 0, -1, TO, 0));
    repeat (TO + 6) begin @(posedge clk); #1; end
    chk("timeout_illegal", {31'h0, illegal}, 32'h1);
    chk("sb_empty_final", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
